// File: rtl/ascon_hash_seq_if.sv
// Job/result handshake bundle between the bus/test wrapper and ascon_hash_seq.
// master: the wrapper offering jobs and consuming digests.
// slave : the sequencer.
interface ascon_hash_seq_if #(
    parameter int Y = 40,
    parameter int L = 256
) ();
    logic           in_valid;
    logic           in_ready;
    logic [Y-1:0]   in_msg;
    logic [Y-1:0]   in_m1;
    logic [Y-1:0]   in_m2;
    logic [447:0]   in_r64;
    logic [L-1:0]   in_rfault;
    logic           out_valid;
    logic           out_ready;
    logic [L-1:0]   out_hash;
    logic           out_err;

    modport master (
        output in_valid, in_msg, in_m1, in_m2, in_r64, in_rfault, out_ready,
        input  in_ready, out_valid, out_hash, out_err
    );

    modport slave (
        input  in_valid, in_msg, in_m1, in_m2, in_r64, in_rfault, out_ready,
        output in_ready, out_valid, out_hash, out_err
    );
endinterface

// File: rtl/ascon_hash_seq.sv
// ascon_hash_seq: accepts one parallel hash job, resets the serial Ascon core,
// shifts the message shares and randomness in MSB first, starts the core,
// collects the serial digest and returns it over a valid/ready handshake.
// Optional watchdog on the BUSY wait: define ASCON_SEQ_TIMEOUT_EN.
module ascon_hash_seq #(
    parameter int Y       = 40,
    parameter int L       = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    ascon_hash_seq_if.slave     bus,
    output logic                busy,
    output logic                core_rst,
    output logic [2:0]          core_messagexSI,
    output logic [6:0]          core_r_64xSI,
    output logic                core_r_faultxSI,
    output logic                core_startxSI,
    input  logic                core_hash_textxSO,
    input  logic                core_readyxSO
);
    // Load length covers the longest serial vector; the counter also spans L.
    localparam int N  = (Y > L) ? ((Y > 64) ? Y : 64) : ((L > 64) ? L : 64);
    localparam int CW = $clog2(((N > L) ? N : L) + 1);
    localparam int YW = $clog2(Y);
    localparam int LW = $clog2(L);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CORE_RST = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_PAD      = 3'd3;
    localparam logic [2:0] S_START    = 3'd4;
    localparam logic [2:0] S_BUSY     = 3'd5;
    localparam logic [2:0] S_COLLECT  = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]     state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic [Y-1:0]   msg_reg, m1_reg, m2_reg;
    logic [447:0]   r64_reg;
    logic [L-1:0]   rf_reg;
    logic [L-1:0]   hash_reg;
    logic           accept;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = (state_reg == S_IDLE) && !rst;
    assign bus.out_valid = (state_reg == S_DONE) && !rst;
    assign bus.out_hash  = hash_reg;
    assign busy          = (state_reg != S_IDLE) && !rst;
    assign core_rst      = rst || (state_reg == S_CORE_RST);
    assign core_startxSI = (state_reg == S_START) && !rst;

`ifdef ASCON_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0]  wd_reg;
    logic           err_reg;
    logic           timeout_hit;

    assign timeout_hit = (state_reg == S_BUSY) && !core_readyxSO
                         && (wd_reg == WW'(TIMEOUT - 1));
    assign bus.out_err = err_reg;

    // Watchdog: counts BUSY cycles, restarted from the START cycle.
    always_ff @(posedge clk) begin
        if (rst || state_reg == S_START)
            wd_reg <= '0;
        else if (state_reg == S_BUSY)
            wd_reg <= wd_reg + WW'(1);
    end

    // Error flag: set on watchdog expiry, cleared when the result is taken.
    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if (timeout_hit)
            err_reg <= 1'b1;
        else if (state_reg == S_DONE && bus.out_ready)
            err_reg <= 1'b0;
    end
`else
    assign bus.out_err = 1'b0;
    // Watchdog disabled: BUSY waits for the core indefinitely.
    if (TIMEOUT > 0) begin : g_no_watchdog
    end
`endif

    // Next-state logic for the job sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (accept) state_next = S_CORE_RST;
            S_CORE_RST: state_next = S_LOAD;
            S_LOAD:     if (cnt_reg == CW'(N - 1)) state_next = S_PAD;
            S_PAD:      state_next = S_START;
            S_START:    state_next = S_BUSY;
            S_BUSY: begin
                if (core_readyxSO)
                    state_next = S_COLLECT;
`ifdef ASCON_SEQ_TIMEOUT_EN
                else if (timeout_hit)
                    state_next = S_DONE;
`endif
            end
            S_COLLECT:  if (cnt_reg == CW'(L - 1)) state_next = S_DONE;
            S_DONE:     if (bus.out_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register and the shared load/collect bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_CORE_RST, S_BUSY: cnt_reg <= '0;
                S_LOAD, S_COLLECT:  cnt_reg <= cnt_reg + CW'(1);
                default:            cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Shadow copy of the job, captured only in the accept cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            msg_reg <= bus.in_msg;
            m1_reg  <= bus.in_m1;
            m2_reg  <= bus.in_m2;
            r64_reg <= bus.in_r64;
            rf_reg  <= bus.in_rfault;
        end
    end

    // Digest assembly: serial bit k lands in hash bit k; cleared on watchdog abort.
    always_ff @(posedge clk) begin
        if (rst)
            hash_reg <= '0;
        else if (state_reg == S_COLLECT)
            hash_reg[cnt_reg[LW-1:0]] <= core_hash_textxSO;
`ifdef ASCON_SEQ_TIMEOUT_EN
        else if (timeout_hit)
            hash_reg <= '0;
`endif
    end

    // Serial load: vector of length V drives bit V-1-cnt while cnt < V, else 0.
    logic           load_active, y_live, w_live, l_live;
    logic [YW-1:0]  y_idx;
    logic [5:0]     w_idx;
    logic [LW-1:0]  l_idx;

    assign load_active = (state_reg == S_LOAD) && !rst;
    assign y_live      = load_active && (cnt_reg < CW'(Y));
    assign w_live      = load_active && (cnt_reg < CW'(64));
    assign l_live      = load_active && (cnt_reg < CW'(L));
    assign y_idx       = YW'(Y - 1) - cnt_reg[YW-1:0];
    assign w_idx       = 6'd63 - cnt_reg[5:0];
    assign l_idx       = LW'(L - 1) - cnt_reg[LW-1:0];

    assign core_messagexSI = y_live ? {m2_reg[y_idx], m1_reg[y_idx], msg_reg[y_idx]} : 3'b000;
    assign core_r_faultxSI = l_live & rf_reg[l_idx];

    for (genvar gi = 0; gi < 7; gi++) begin : g_r64
        logic [63:0] word;
        assign word             = r64_reg[64*gi +: 64];
        assign core_r_64xSI[gi] = w_live & word[w_idx];
    end
endmodule

// File: tb/tb_ascon_hash_seq.sv
// Bench for ascon_hash_seq: a behavioural stub core captures the serial load,
// returns a digest derived from what it captured, and a scoreboard holds the
// digest/latency the bench expects for each submitted job.
module tb_ascon_hash_seq;
    localparam int Y  = 40;
    localparam int L  = 256;
    localparam int N  = 256;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_hash_seq_if #(.Y(Y), .L(L)) bus ();

    logic       busy, core_rst;
    logic [2:0] core_messagexSI;
    logic [6:0] core_r_64xSI;
    logic       core_r_faultxSI, core_startxSI;
    logic       core_hash_textxSO = 1'b0;
    logic       core_readyxSO     = 1'b0;

    ascon_hash_seq #(.Y(Y), .L(L), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .busy              (busy),
        .core_rst          (core_rst),
        .core_messagexSI   (core_messagexSI),
        .core_r_64xSI      (core_r_64xSI),
        .core_r_faultxSI   (core_r_faultxSI),
        .core_startxSI     (core_startxSI),
        .core_hash_textxSO (core_hash_textxSO),
        .core_readyxSO     (core_readyxSO)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Digest the stub returns, as a function of the job contents.
    function automatic logic [255:0] digest_of(input logic [39:0] m, a, b,
                                               input logic [447:0] r, input logic [255:0] rf);
        return rf ^ {b, 136'b0, a, m} ^ r[255:0] ^ {64'b0, r[447:256]};
    endfunction

    // ---------------- stub core ----------------
    localparam logic [1:0] P_IDLE = 2'd0, P_LOAD = 2'd1, P_WAIT = 2'd2, P_RUN = 2'd3;
    logic [1:0]   ph = P_IDLE;
    int           ld_cnt = 0, run_cnt = 0, emit_idx = 0, start_pos = 0;
    logic [39:0]  cap_msg, cap_m1, cap_m2;
    logic [447:0] cap_r;
    logic [255:0] cap_rf, msg_trace, digest;
    bit           stray = 1'b0;
    int           stub_d = 0;
    bit           stub_stale = 1'b0;

    always @(posedge clk) begin
        if (core_rst) begin
            ph <= P_LOAD; ld_cnt <= 0; stray <= 1'b0; msg_trace <= '0;
            core_readyxSO <= 1'b0; core_hash_textxSO <= 1'b0;
        end else begin
            case (ph)
                P_LOAD: begin
                    if (ld_cnt < Y) begin
                        cap_msg[Y-1-ld_cnt] <= core_messagexSI[0];
                        cap_m1[Y-1-ld_cnt]  <= core_messagexSI[1];
                        cap_m2[Y-1-ld_cnt]  <= core_messagexSI[2];
                    end else if (core_messagexSI != 3'b000) stray <= 1'b1;
                    msg_trace[ld_cnt] <= core_messagexSI[0];
                    for (int w = 0; w < 7; w++) begin
                        if (ld_cnt < 64) cap_r[64*w+63-ld_cnt] <= core_r_64xSI[w];
                        else if (core_r_64xSI[w]) stray <= 1'b1;
                    end
                    cap_rf[L-1-ld_cnt] <= core_r_faultxSI;
                    if (core_startxSI) stray <= 1'b1;
                    if (ld_cnt == N-1) begin
                        ph <= P_WAIT;
                        if (stub_stale) core_readyxSO <= 1'b1;
                    end
                    ld_cnt <= ld_cnt + 1;
                end
                P_WAIT: begin
                    if (core_messagexSI != 0 || core_r_64xSI != 0 || core_r_faultxSI) stray <= 1'b1;
                    ld_cnt <= ld_cnt + 1;
                    if (core_startxSI) begin
                        start_pos <= ld_cnt; ph <= P_RUN; run_cnt <= 0; emit_idx <= 0;
                        digest <= digest_of(cap_msg, cap_m1, cap_m2, cap_r, cap_rf);
                        core_readyxSO <= (stub_d == 0);
                    end
                end
                P_RUN: begin
                    if (core_messagexSI != 0 || core_r_64xSI != 0 || core_r_faultxSI || core_startxSI)
                        stray <= 1'b1;
                    if (!core_readyxSO) begin
                        if (run_cnt + 1 == stub_d) core_readyxSO <= 1'b1;
                        run_cnt <= run_cnt + 1;
                    end else if (emit_idx < L) begin
                        core_hash_textxSO <= digest[emit_idx];
                        emit_idx <= emit_idx + 1;
                    end else begin
                        core_hash_textxSO <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard / checks ----------------
    typedef struct {
        logic [39:0]  m, a, b;
        logic [447:0] r;
        logic [255:0] rf, hash;
        logic         err;
        int           lat;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int acc = 0;
    int job_no = 0;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [447:0] rnd();
        logic [447:0] v;
        for (int i = 0; i < 14; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic submit(input logic [39:0] m, a, b, input logic [447:0] r,
                          input logic [255:0] rf, input int d, input bit stale, input bit wd);
        exp_t e;
        int   n;
        logic [447:0] junk;
        stub_d = d; stub_stale = stale;
        bus.in_msg = m; bus.in_m1 = a; bus.in_m2 = b; bus.in_r64 = r; bus.in_rfault = rf;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin tick; n++; end
        chk("accept_wait", 1'(n < 200), 1'b1);
        tick;
        acc = cyc;
        bus.in_valid = 1'b0;
        junk = rnd();
        bus.in_msg = junk[39:0]; bus.in_m1 = junk[79:40]; bus.in_m2 = junk[119:80];
        bus.in_r64 = rnd(); bus.in_rfault = junk[447:192];
        e.m = m; e.a = a; e.b = b; e.r = r; e.rf = rf;
        e.err  = wd;
        e.hash = wd ? 256'b0 : digest_of(m, a, b, r, rf);
        e.lat  = wd ? (1 + N + 1 + 1 + TO) : (1 + N + 1 + 1 + (d + 1) + L);
        sb.push_back(e);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   n;
        logic [255:0] trace;
        bus.out_ready = (hold == 0);
        n = 0;
        while (!bus.out_valid && n < 3000) begin tick; n++; end
        if (n >= 3000) begin
            chk("out_valid_wait", 1'b0, 1'b1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        job_no++;
        $display("job %0d: latency=%0d err=%0d hash=%h", job_no, cyc - acc, bus.out_err, bus.out_hash);
        chk("latency", 448'(cyc - acc), 448'(e.lat));
        chk("out_hash", bus.out_hash, e.hash);
        chk("out_err", bus.out_err, e.err);
        if (!e.err) begin
            trace = '0;
            for (int k = 0; k < Y; k++) trace[k] = e.m[Y-1-k];
            chk("load_msg_trace", msg_trace, trace);
            chk("load_shares", {cap_m2, cap_m1, cap_msg}, {e.b, e.a, e.m});
            chk("load_r64", cap_r, e.r);
            chk("load_rfault", cap_rf, e.rf);
            chk("start_pos", 448'(start_pos), 448'(N + 1));
            chk("serial_stray", stray, 1'b0);
        end
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                chk("bp_hash", bus.out_hash, e.hash);
                chk("bp_flags", {bus.in_ready, bus.out_valid, busy}, 3'b011);
                tick;
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        tick;
        chk("idle_after_done", {bus.in_ready, bus.out_valid, busy, bus.out_err}, 4'b1000);
    endtask

    initial begin
        logic [447:0] v;
        int n;
        bit seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.in_msg = '0; bus.in_m1 = '0; bus.in_m2 = '0; bus.in_r64 = '0; bus.in_rfault = '0;

        // Reset held 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_flags", {bus.in_ready, bus.out_valid, bus.out_err, busy, core_rst}, 5'b00001);
            chk("rst_serial", {core_messagexSI, core_r_64xSI, core_r_faultxSI, core_startxSI}, 12'h0);
            chk("rst_hash", bus.out_hash, 256'h0);
        end
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", bus.in_ready, 1'b1);

        // Load ordering job with back-pressure.
        v = rnd();
        submit(40'h80_0000_0001, v[39:0], v[79:40], rnd(), v[447:192], 3, 1'b0, 1'b0);
        collect(20);

        // Stale ready in START, then a back-to-back job.
        v = rnd();
        submit(v[39:0], v[79:40], v[119:80], rnd(), v[447:192], 2, 1'b1, 1'b0);
        collect(0);
        v = rnd();
        submit(v[39:0], v[79:40], v[119:80], rnd(), v[447:192], 7, 1'b0, 1'b0);
        collect(0);

        // Reset in COLLECT at cnt = 100.
        v = rnd();
        submit(v[39:0], v[79:40], v[119:80], rnd(), v[447:192], 0, 1'b0, 1'b0);
        n = 0;
        while (cyc != acc + N + 3 + 1 + 100 && n < 1000) begin tick; n++; end
        chk("reach_collect", {1'(n < 1000), busy}, 2'b11);
        rst = 1'b1;
        #1;
        chk("midjob_core_rst", {core_rst, bus.out_valid}, 2'b10);
        tick;
        rst = 1'b0;
        #1;
        chk("midjob_idle", {bus.in_ready, bus.out_valid, busy}, 3'b100);
        chk("midjob_hash", bus.out_hash, 256'h0);
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midjob_no_valid", seen, 1'b0);
        void'(sb.pop_back());
        $display("job (reset mid-collect): discarded");

        // Normal job after the aborted one.
        v = rnd();
        submit(v[39:0], v[79:40], v[119:80], rnd(), v[447:192], 1, 1'b0, 1'b0);
        collect(0);

`ifdef ASCON_SEQ_TIMEOUT_EN
        // Core never completes: watchdog aborts into DONE.
        v = rnd();
        submit(v[39:0], v[79:40], v[119:80], rnd(), v[447:192], -1, 1'b0, 1'b1);
        collect(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ascon_hash_seq.md
# ascon_hash_seq

Job sequencer for the serial-interface Ascon hash core. It accepts one complete hash job as parallel words over a valid/ready handshake and resets the core. It then shifts the message shares and randomness into the core's serial load ports, issues start, collects the serial digest, and returns it as a parallel word over a second valid/ready handshake. It sits between the bus/test wrapper and the hash core; the core instance is owned exclusively by this block.

## Interface
- Y, 40, message length in bits (core `y`)
- L, 256, digest and fault-randomness length in bits (core `l`)
- TIMEOUT, 4096, watchdog limit in BUSY cycles (used only with `ASCON_SEQ_TIMEOUT_EN`)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  block can accept a job (high only in IDLE)
- in_msg  in  Y  message share 0
- in_m1  in  Y  message share 1
- in_m2  in  Y  message share 2
- in_r64  in  448  seven 64-bit random words; word n is bits [64n+63:64n]
- in_rfault  in  L  fault-countermeasure randomness
- out_valid  out  1  digest available
- out_ready  in  1  consumer accepts digest
- out_hash  out  L  digest; bit k is the k-th serial output bit
- out_err  out  1  job aborted by watchdog (0 when macro absent)
- busy  out  1  high in every state except IDLE
- core_rst  out  1  core reset; equals `rst` OR (state == CORE_RST)
- core_messagexSI  out  3  serial bits {m2, m1, msg}
- core_r_64xSI  out  7  serial bits, bit n from in_r64 word n
- core_r_faultxSI  out  1  serial fault-randomness bit
- core_startxSI  out  1  core start
- core_hash_textxSO  in  1  serial digest bit
- core_readyxSO  in  1  core done

## Operation
- N = max(Y, L, 64) is the load length. Internal counter `cnt` is `$clog2(max(N,L)+1)` bits wide.
- **IDLE**: `in_ready` = 1. When `in_valid & in_ready`, latch all inputs into shadow registers and go to CORE_RST.
- **CORE_RST** (1 cycle): `core_rst` = 1, `cnt` cleared. Next state is LOAD.
- **LOAD** (N cycles, cnt = 0..N-1): for each vector of length V, drive bit V-1-cnt when cnt < V, otherwise drive 0. Vectors load MSB first. When cnt = N-1, go to PAD.
- **PAD** (1 cycle): all serial inputs are 0. This cycle lets the core's load counter pass N.
- **START** (1 cycle): `core_startxSI` = 1, then go to BUSY.
- **BUSY**: wait for `core_readyxSO` = 1, then clear `cnt` and go to COLLECT.
- **COLLECT** (L cycles): each cycle, shift `core_hash_textxSO` into `out_hash[cnt]` and increment `cnt`. The first sample is taken on the cycle after `core_readyxSO` is first seen high. After bit L-1, go to DONE.
- **DONE**: `out_valid` = 1 and `out_hash`/`out_err` are held stable. On `out_valid & out_ready`, go to IDLE.
- The shadow registers are not cleared between jobs. All serial outputs are 0 in every state other than LOAD.

## Timing
- Reset values:
  - `in_ready` = 0 during rst and 1 on the first cycle after.
  - `out_valid` = 0, `out_hash` = 0, `out_err` = 0, `busy` = 0.
  - `core_rst` = 1 while rst is high.
  - All serial outputs = 0, and the state is IDLE.
- Reset mid-job: the job is discarded with no output. The core is reset through `core_rst`.
- Latency: accept to `out_valid` is 1 + N + 1 + 1 + P + L cycles, where P is the number of cycles from START until `core_readyxSO` is seen high.
- Late `core_readyxSO` (already high in START, e.g. stale): it is ignored. Only BUSY samples it.
- `out_ready` held low: DONE persists indefinitely and `in_ready` stays 0.
- `out_ready` high on `out_valid`'s first cycle: the block returns to IDLE and can accept the next job the following cycle. There is no bubble beyond that.
- `in_valid` while busy: not accepted and has no effect. Inputs need only be stable in the accept cycle.

## Configuration
- `ASCON_SEQ_TIMEOUT_EN` defined:
  - A watchdog counts BUSY cycles.
  - If TIMEOUT cycles elapse without `core_readyxSO`, go to DONE with `out_err` = 1 and `out_hash` = 0.
  - `out_err` clears on leaving DONE.
- Not defined: BUSY waits forever, `out_err` is tied 0, and no watchdog logic is generated.

## Test plan
- **Reset**: hold rst for 3 cycles.
  - Outputs match the reset values, with `core_rst` = 1 throughout.
  - `in_ready` = 1 on cycle 4.
- **Load ordering**: Y=40, L=256, in_msg = 40'h80_0000_0001.
  - `core_messagexSI[0]` is 1 in LOAD cycle 0, 1 in cycle 39, and 0 in cycles 1–38 and 40–255.
  - PAD follows LOAD cycle 255, and `core_startxSI` is high exactly one cycle later.
- **Full job on the real core** with a known test vector.
  - `out_hash` matches the golden digest.
  - Latency is 515 + P cycles.
- **Back-pressure**: hold `out_ready` = 0 for 20 cycles in DONE.
  - `out_hash` is stable, `in_ready` = 0, and a held `in_valid` is not accepted.
  - After `out_ready` rises, the block is in IDLE on the next cycle.
- **Reset mid-COLLECT** at cnt = 100.
  - IDLE on the next cycle, `out_valid` is never asserted, and `core_rst` = 1 during rst.
- **Watchdog** (`ASCON_SEQ_TIMEOUT_EN`, TIMEOUT = 16): the stub core never raises ready.
  - DONE is entered 16 cycles after entering BUSY, with `out_err` = 1 and `out_hash` = 0.
